wb_port_arbiter: RTL

//  Shares the single register-file write port between in-order writebacks leaving MEM/WB and
//  out-of-band results from a long-latency unit (divider, late load). Buffers unit results in a

---
 rtl/wb_port_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter for pipeline writebacks and long-latency unit results
//
// Shares the single regfile write port between the in-order MEM/WB writeback and
// out-of-band results from a long-latency unit (divider, late load). Unit results
// that cannot be written straight away go into a small FIFO. The FIFO drains on
// cycles when the pipeline is not writing. If the FIFO head waits too long, the
// pipeline is held so that the head can be written.
//
// Parameters
//   XLEN          data width (32 or 64)
//   DEPTH         result FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  cycles a non-empty FIFO may go unserved before the pipeline is held (>= 1)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   pipe_valid  WB stage holds a valid instruction
//   pipe_we     WB instruction writes rd
//   pipe_rd     WB destination register
//   pipe_wdata  WB write data (already muxed)
//   pipe_stall  hold the WB instruction and the upstream stages this cycle
//   lu_valid    unit result available
//   lu_rd       unit destination register
//   lu_wdata    unit result
//   lu_ready    arbiter accepts the unit result this cycle
//   rf_we       regfile write enable
//   rf_rd       regfile write address
//   rf_wdata    regfile write data
//   rd_pending  bit i set = FIFO holds a result for x i (bit 0 always 0)

module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_valid,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wdata,
    output logic            pipe_stall,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_wdata,
    output logic            lu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     rd_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Grant source selected for the write port in the current cycle
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_PIPE   = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } src_t;

    // FIFO storage and bookkeeping
    logic [4:0]      ent_rd    [DEPTH];
    logic [XLEN-1:0] ent_data  [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [SW-1:0]   starve;

    logic fifo_nonempty;
    logic starved;
    logic pipe_req;
    logic lu_req;
    logic pop;
    logic push;
    src_t src;

    assign fifo_nonempty = (count != '0);
    assign starved       = fifo_nonempty && (starve == STARVE_MAX);
    assign pipe_req      = pipe_valid && pipe_we && (pipe_rd != 5'd0);
    assign lu_req        = lu_valid && (lu_rd != 5'd0);

    // lu_ready looks only at the registered count, so a pop in the same cycle
    // does not open a slot; a producer facing a full FIFO retries next cycle.
    assign lu_ready = !reset && (count < FULL_COUNT);

    // Write-port arbitration, purely combinational from state and inputs
    always_comb begin
        src        = SRC_NONE;
        pipe_stall = 1'b0;
        if (!reset) begin
            if (starved) begin
                src        = SRC_FIFO;
                pipe_stall = pipe_valid;
            end else if (pipe_req) begin
                src = SRC_PIPE;
            end else if (fifo_nonempty) begin
                src = SRC_FIFO;
            end else if (lu_req) begin
                // Only when the FIFO is empty, so unit results never overtake buffered ones
                src = SRC_BYPASS;
            end
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = 5'd0;
        rf_wdata = '0;
        unique case (src)
            SRC_PIPE: begin
                rf_we    = 1'b1;
                rf_rd    = pipe_rd;
                rf_wdata = pipe_wdata;
            end
            SRC_FIFO: begin
                rf_we    = 1'b1;
                rf_rd    = ent_rd[rd_ptr];
                rf_wdata = ent_data[rd_ptr];
            end
            SRC_BYPASS: begin
                rf_we    = 1'b1;
                rf_rd    = lu_rd;
                rf_wdata = lu_wdata;
            end
            default: begin
                rf_we    = 1'b0;
            end
        endcase
    end

    assign pop  = (src == SRC_FIFO);
    // lu_rd == 0 is accepted (lu_ready high) but never stored
    assign push = lu_req && lu_ready && (src != SRC_BYPASS);

    // FIFO pointers, count and per-entry contents.
    // Push and pop never target the same slot: push needs count < DEPTH and
    // pop needs count > 0, so with equal pointers only one of them can fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // Entry payloads need no reset; ent_valid guards every use
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wr_ptr]   <= lu_rd;
            ent_data[wr_ptr] <= lu_wdata;
        end
    end

    // Starvation counter: counts cycles in which the head waits without a pop.
    // It saturates at the limit, and the pipeline is then held until the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve <= '0;
        end else if (pop || !fifo_nonempty) begin
            starve <= '0;
        end else if (starve != STARVE_MAX) begin
            starve <= starve + 1'b1;
        end
    end

    // Pending-destination mask. It is an OR over the valid entries, so a register
    // held by several buffered results stays pending until the last one pops.
    // It is derived only from registered state, so it changes at clock edges.
    always_comb begin
        rd_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                rd_pending[ent_rd[i]] = 1'b1;
            end
        end
        rd_pending[0] = 1'b0;
    end

endmodule
